// File: rtl/alu_op_a_sched.sv
// alu_op_a_sched: schedules ownership of the ALU operand-A source mux among
// four requesters (0: interrupt controller, 1: decoder micro-op,
// 2: PC incrementer, 3: block-transfer address incrementer).
//
// Ports:
//   clk          system clock, rising-edge active
//   reset        asynchronous, active-high reset
//   req          per-requester request, bit index = requester number
//   src0..src3   requested operand-A select per requester (zero or one-hot)
//   len          per-requester op length: 0 = 1 cycle, 1 = 2 cycles
//   flush        synchronous abort of the current ownership
//   grant        registered one-hot owner, zero when idle
//   data_select  registered select to the operand-A mux
//   done         high during the final owned cycle (decoded from state)
//   busy         high whenever an owner exists (decoded from state)
//   src_err      one-cycle pulse when the granted src was multi-hot
`timescale 1ns/1ps

module alu_op_a_sched #(
    parameter int unsigned SEL_WIDTH = 5,
    parameter int unsigned NREQ      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [SEL_WIDTH-1:0] src0,
    input  logic [SEL_WIDTH-1:0] src1,
    input  logic [SEL_WIDTH-1:0] src2,
    input  logic [SEL_WIDTH-1:0] src3,
    input  logic [NREQ-1:0]      len,
    input  logic                 flush,
    output logic [NREQ-1:0]      grant,
    output logic [SEL_WIDTH-1:0] data_select,
    output logic                 done,
    output logic                 busy,
    output logic                 src_err
);

    localparam int unsigned IDX_W = 2;
    localparam int unsigned RR_W  = 3;

    // OWN2 is the first cycle of a 2-cycle op; OWN1 is the final (or only) one.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN1 = 2'd1,
        OWN2 = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [NREQ-1:0]      grant_q, grant_d;
    logic [SEL_WIDTH-1:0] sel_q,   sel_d;
    logic [IDX_W-1:0]     ptr_q,   ptr_d;
    logic                 err_q,   err_d;

    logic [NREQ-1:0]      cand_c;
    logic                 win_vld_c;
    logic [IDX_W-1:0]     win_c;
    logic [RR_W-1:0]      rr_idx_c;
    logic [SEL_WIDTH-1:0] win_src_c;
    logic                 win_multi_c;

    // True when more than one bit of a select is set.
    function automatic logic is_multi_hot(input logic [SEL_WIDTH-1:0] s);
        return (s & (s - SEL_WIDTH'(1))) != '0;
    endfunction

    // Candidate set: the requester finishing its final cycle is excluded so a
    // still-asserted req cannot immediately re-win.
    always_comb begin
        cand_c = req;
        if (state_q == OWN1) begin
            cand_c = req & ~grant_q;
        end
    end

    // Winner: requester 0 is absolute priority, 1..3 round-robin after ptr.
    always_comb begin
        win_vld_c = 1'b0;
        win_c     = '0;
        rr_idx_c  = '0;
        if (cand_c[0]) begin
            win_vld_c = 1'b1;
            win_c     = '0;
        end else begin
            for (int unsigned k = 1; k <= 3; k++) begin
                // Walk ptr+1, ptr+2, ptr+3 with 3 wrapping back to 1.
                rr_idx_c = RR_W'(ptr_q) + RR_W'(k);
                if (rr_idx_c > RR_W'(3)) begin
                    rr_idx_c = rr_idx_c - RR_W'(3);
                end
                if (!win_vld_c && cand_c[rr_idx_c[IDX_W-1:0]]) begin
                    win_vld_c = 1'b1;
                    win_c     = rr_idx_c[IDX_W-1:0];
                end
            end
        end
    end

    // Select the winner's requested source.
    always_comb begin
        win_src_c = '0;
        case (win_c)
            2'd0:    win_src_c = src0;
            2'd1:    win_src_c = src1;
            2'd2:    win_src_c = src2;
            default: win_src_c = src3;
        endcase
        win_multi_c = is_multi_hot(win_src_c);
    end

    // Next-state and register-input logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        err_d   = 1'b0;

        if (flush) begin
            // Abort without arbitrating; pointer keeps its value.
            state_d = IDLE;
            grant_d = '0;
            sel_d   = '0;
        end else begin
            case (state_q)
                OWN2: begin
                    // Locked: owner keeps the mux for its second pass.
                    state_d = OWN1;
                end
                IDLE, OWN1: begin
                    if (win_vld_c) begin
                        grant_d = NREQ'(1) << win_c;
                        // Multi-hot sources fall back to the regfile default.
                        sel_d   = win_multi_c ? '0 : win_src_c;
                        err_d   = win_multi_c;
                        state_d = len[win_c] ? OWN2 : OWN1;
                        if (win_c != '0) begin
                            ptr_d = win_c;
                        end
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        sel_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    grant_d = '0;
                    sel_d   = '0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= IDX_W'(3);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    assign grant       = grant_q;
    assign data_select = sel_q;
    assign src_err     = err_q;
    assign done        = (state_q == OWN1);
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_op_a_sched.sv
// Scoreboard bench for alu_op_a_sched: a behavioural owner/remaining-cycles
// model predicts each cycle's outputs; a negedge monitor compares them.
`timescale 1ns/1ps

module tb_alu_op_a_sched;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = '0;
    logic [4:0] src0  = '0;
    logic [4:0] src1  = '0;
    logic [4:0] src2  = '0;
    logic [4:0] src3  = '0;
    logic [3:0] len   = '0;
    logic       flush = 1'b0;
    logic [3:0] grant;
    logic [4:0] data_select;
    logic       done;
    logic       busy;
    logic       src_err;

    alu_op_a_sched #(.SEL_WIDTH(5), .NREQ(4)) dut (
        .clk(clk), .reset(reset), .req(req),
        .src0(src0), .src1(src1), .src2(src2), .src3(src3),
        .len(len), .flush(flush),
        .grant(grant), .data_select(data_select),
        .done(done), .busy(busy), .src_err(src_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] grant;
        logic [4:0] sel;
        logic       done;
        logic       busy;
        logic       err;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } dchk_t;

    exp_t  mq[$];
    dchk_t dq[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference model: who owns the mux and how many owned cycles remain.
    int         m_owner = -1;
    int         m_rem   = 0;
    int         m_last  = 3;
    logic [4:0] m_sel   = '0;
    logic       m_err   = 1'b0;

    function automatic logic [4:0] src_of(input int w);
        case (w)
            0:       return src0;
            1:       return src1;
            2:       return src2;
            default: return src3;
        endcase
    endfunction

    task automatic model_step();
        int         w;
        int         r;
        logic [3:0] cand;
        logic [4:0] s;
        if (reset) begin
            m_owner = -1; m_rem = 0; m_last = 3; m_sel = '0; m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (flush) begin
                m_owner = -1; m_rem = 0; m_sel = '0;
            end else if (m_owner >= 0 && m_rem == 2) begin
                m_rem = 1;
            end else begin
                cand = req;
                if (m_owner >= 0) cand[m_owner] = 1'b0;
                w = -1;
                if (cand[0]) begin
                    w = 0;
                end else begin
                    for (int k = 1; k <= 3; k++) begin
                        r = ((m_last - 1 + k) % 3) + 1;
                        if (w < 0 && cand[r]) w = r;
                    end
                end
                if (w >= 0) begin
                    m_owner = w;
                    m_rem   = len[w] ? 2 : 1;
                    s       = src_of(w);
                    if ($countones(s) > 1) begin
                        m_sel = '0; m_err = 1'b1;
                    end else begin
                        m_sel = s;
                    end
                    if (w != 0) m_last = w;
                end else begin
                    m_owner = -1; m_rem = 0; m_sel = '0;
                end
            end
        end
    endtask

    // One clock: update the model at the edge, queue the prediction, return at negedge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_step();
        e.grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e.sel   = m_sel;
        e.done  = (m_rem == 1);
        e.busy  = (m_owner >= 0);
        e.err   = m_err;
        mq.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        dchk_t d;
        d.name = name; d.act = act; d.exp = exp;
        dq.push_back(d);
    endtask

    task automatic cmpv(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare the model's prediction and any directed checks.
    always @(negedge clk) begin : mon
        exp_t  e;
        dchk_t d;
        #1;
        if (mq.size() > 0) begin
            e = mq.pop_front();
            cmpv("grant",       32'(grant),       32'(e.grant));
            cmpv("data_select", 32'(data_select), 32'(e.sel));
            cmpv("done",        32'(done),        32'(e.done));
            cmpv("busy",        32'(busy),        32'(e.busy));
            cmpv("src_err",     32'(src_err),     32'(e.err));
        end
        while (dq.size() > 0) begin
            d = dq.pop_front();
            cmpv(d.name, d.act, d.exp);
        end
    end

    function automatic logic [4:0] rand_src();
        int unsigned sel;
        int unsigned b1;
        int unsigned b2;
        sel = $urandom_range(0, 7);
        b1  = $urandom_range(0, 4);
        b2  = (b1 + 1 + $urandom_range(0, 3)) % 5;
        if (sel == 0) return 5'b00000;
        if (sel == 1) return 5'(1 << b1) | 5'(1 << b2);
        return 5'(1 << b1);
    endfunction

    initial begin
        // Reset state.
        repeat (3) tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        reset = 1'b0;
        tick();

        // Single-cycle grant to requester 1.
        src1 = 5'b00001; len = 4'b0000; req = 4'b0010;
        tick();
        chk("t1_grant", 32'(grant), 32'h2);
        chk("t1_sel",   32'(data_select), 32'h01);
        chk("t1_done",  32'(done), 32'h1);
        req = 4'b0000;
        tick();
        chk("t1_idle_grant", 32'(grant), 32'h0);
        chk("t1_idle_busy",  32'(busy),  32'h0);

        // Two-cycle grant to requester 0, req held through the lock.
        src0 = 5'b10000; len = 4'b0001; req = 4'b0001;
        tick();
        chk("t2_grant_a", 32'(grant), 32'h1);
        chk("t2_sel_a",   32'(data_select), 32'h10);
        chk("t2_done_a",  32'(done), 32'h0);
        tick();
        chk("t2_grant_b", 32'(grant), 32'h1);
        chk("t2_sel_b",   32'(data_select), 32'h10);
        chk("t2_done_b",  32'(done), 32'h1);
        tick();
        chk("t2_excluded", 32'(grant), 32'h0);
        tick();
        chk("t2_regrant", 32'(grant), 32'h1);
        req = 4'b0000;
        repeat (2) tick();

        // Round-robin sequence from a fresh pointer.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        src1 = 5'b00010; src2 = 5'b00100; src3 = 5'b01000; len = 4'b0000;
        for (int pass = 0; pass < 2; pass++) begin
            req = 4'b1110;
            tick();
            chk("rr_g1", 32'(grant), 32'h2);
            chk("rr_s1", 32'(data_select), 32'h02);
            req = 4'b1100;
            tick();
            chk("rr_g2", 32'(grant), 32'h4);
            req = 4'b1000;
            tick();
            chk("rr_g3", 32'(grant), 32'h8);
        end
        req = 4'b0000;
        tick();
        chk("rr_idle", 32'(busy), 32'h0);

        // Interrupt waits for a 2-cycle lock, then wins immediately.
        src2 = 5'b00100; len = 4'b0100; req = 4'b0100;
        tick();
        chk("lk_grant_a", 32'(grant), 32'h4);
        chk("lk_done_a",  32'(done),  32'h0);
        req = 4'b0001;
        tick();
        chk("lk_grant_b", 32'(grant), 32'h4);
        chk("lk_done_b",  32'(done),  32'h1);
        tick();
        chk("lk_irq", 32'(grant), 32'h1);
        req = 4'b0000;
        tick();

        // Multi-hot source.
        src3 = 5'b00110; len = 4'b0000; req = 4'b1000;
        tick();
        chk("mh_grant", 32'(grant), 32'h8);
        chk("mh_sel",   32'(data_select), 32'h0);
        chk("mh_err",   32'(src_err), 32'h1);
        req = 4'b0000;
        tick();
        chk("mh_err_clr", 32'(src_err), 32'h0);

        // Flush during OWN2.
        src1 = 5'b00001; len = 4'b0010; req = 4'b0010;
        tick();
        chk("fl_grant_a", 32'(grant), 32'h2);
        flush = 1'b1;
        tick();
        chk("fl_grant", 32'(grant), 32'h0);
        chk("fl_done",  32'(done),  32'h0);
        flush = 1'b0; req = 4'b0000;
        tick();

        // Asynchronous reset mid-OWN2.
        req = 4'b0010;
        tick();
        req = 4'b0000;
        #2 reset = 1'b1;
        #1;
        chk("ar_grant", 32'(grant), 32'h0);
        chk("ar_sel",   32'(data_select), 32'h0);
        chk("ar_busy",  32'(busy), 32'h0);
        chk("ar_done",  32'(done), 32'h0);
        repeat (2) tick();
        reset = 1'b0; len = 4'b0000; req = 4'b1110;
        tick();
        chk("ar_first", 32'(grant), 32'h2);
        req = 4'b0000;
        tick();

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            req   = 4'($urandom);
            len   = 4'($urandom);
            src0  = rand_src();
            src1  = rand_src();
            src2  = rand_src();
            src3  = rand_src();
            flush = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush = 1'b0; req = 4'b0000;
        repeat (3) tick();

        #2;
        chk("queue_drained", 32'(mq.size()), 32'h0);
        @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_op_a_sched.md
Name: alu_op_a_sched

Overview:
- Schedules the ALU operand-A source mux among four requesters:
  - 0: interrupt controller
  - 1: instruction decoder micro-op
  - 2: PC incrementer
  - 3: block-transfer address incrementer
- Each granted requester owns the mux for 1 or 2 cycles. 16-bit operations hold the source for both ALU passes.
- Drives the registered one-hot mux select and grant lines, and signals completion.

Parameters:
- SEL_WIDTH, 5: width of the operand-A select bus. Equals MUX_ALU_OP_A_SEL_WIDTH. All-zero selects the 8-bit regfile default.
- NREQ, 4: number of requesters. Fixed at 4; other values are unsupported.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  4  request per requester, bit index = requester number
- src0..src3  in  SEL_WIDTH each  requested select per requester (zero or one-hot)
- len  in  4  per requester: 0 = 1-cycle op, 1 = 2-cycle op
- flush  in  1  synchronous abort of the current ownership
- grant  out  4  one-hot owner of the mux, zero when idle
- data_select  out  SEL_WIDTH  registered select to the operand-A mux
- done  out  1  high during the final owned cycle
- busy  out  1  high whenever grant is nonzero
- src_err  out  1  one-cycle pulse when a granted src is multi-hot

Behaviour:
- Reset values:
  - grant = 0, data_select = 0, done = 0, busy = 0, src_err = 0.
  - state = IDLE, cycle counter = 0, round-robin pointer = 3 (requester 1 wins first).
  - Async reset mid-ownership aborts immediately. No done is produced.
- States:
  - IDLE: no owner.
  - OWN1: final (or only) owned cycle; done = 1.
  - OWN2: first cycle of a 2-cycle op; done = 0.
- Arbitration runs at every rising edge where state is IDLE or OWN1, which allows back-to-back grants.
- Priority:
  - req[0] always wins.
  - Otherwise round-robin over 1..3, searching from pointer+1 with wrap 3 -> 1.
  - Pointer updates to the winner only when the winner is in 1..3.
- Exclusion: at the edge ending OWN1, the finishing requester's req bit is ignored. It must drop req after seeing done.
- Winner w found:
  - grant <= 1<<w.
  - data_select <= src_w latched; it does not track src_w afterwards.
  - Next state = OWN2 if len[w] = 1, else OWN1.
- No winner: next state IDLE; grant and data_select <= 0.
- OWN2 always advances to OWN1 with grant and data_select unchanged. Interrupt requests wait; no preemption inside a lock.
- Latency: req sampled high at edge N (idle, winning) -> grant and data_select valid in cycle N+1. For len = 1, done is high in cycle N+2.
- Multi-hot src at grant:
  - data_select <= 0 (8-bit regfile default).
  - src_err pulses in the first owned cycle.
  - Ownership and timing proceed as normal.
- flush:
  - Sampled high at an edge -> IDLE, grant = 0, data_select = 0, done = 0.
  - No arbitration at that edge; the pointer is unchanged.
  - flush has priority over every transition.
- done and busy are decoded combinationally from state; grant and data_select come directly from registers.
- A requester dropping req while owning has no effect; ownership runs to completion.

Test Plan:
- Reset, then req = 4'b0010, src1 = 5'b00001, len = 0 -> next cycle: grant = 0010, data_select = 00001, done = 1. Following cycle, req dropped: grant = 0, busy = 0.
- req = 4'b0001, src0 = 5'b10000, len[0] = 1 -> grant = 0001 for 2 cycles, data_select = 10000 both cycles, done only in the second. req[0] raised again during OWN2 is not regranted until after done.
- req = 4'b1110 held continuously, all len = 0, each requester dropping req after its done -> grant sequence 0010, 0100, 1000, no idle cycles. Re-raising all three gives the same order from 0010 (pointer wrap).
- req[2] owning a 2-cycle op, req[0] asserted in OWN2 -> req[2] completes; grant = 0001 in the cycle immediately after req[2]'s done.
- src3 = 5'b00110 granted -> data_select = 0, src_err = 1 for one cycle, grant = 1000.
- 2-cycle grant with flush high at the OWN2 edge -> grant = 0, no done. Separately, async reset asserted mid-OWN2 -> all outputs 0 immediately. After reset release, req = 4'b1110 grants requester 1 first.
